// File: rtl/divider_sequencer_if.sv
// Control/status bundle between the divider sequencer and its board-level driver.
// The slave side is the sequencer; the master side drives start/stop and the divided-clock feedback.
interface divider_sequencer_if;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [3:0] load_value;
  logic       div_clk_in;
  logic [1:0] contral;
  logic       load_enable;
  logic [3:0] load_counter;
  logic       busy;
  logic       mode_done;

  modport master (
    output start, stop, loop_en, load_value, div_clk_in,
    input  contral, load_enable, load_counter, busy, mode_done
  );

  modport slave (
    input  start, stop, loop_en, load_value, div_clk_in,
    output contral, load_enable, load_counter, busy, mode_done
  );
endinterface

// File: rtl/divider_sequencer.sv
// Steps the decade divider through its four speed modes, dwelling a fixed number of
// divided-clock edges in each, then stops or reloads and loops.
module divider_sequencer #(
  parameter int DWELL_EDGES = 10,
  parameter int EDGE_W      = 8,
  parameter int LOAD_CYCLES = 5
) (
  input  logic              CLK,
  input  logic              rst,
  divider_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    ADVANCE = 2'd3
  } state_t;

  localparam logic [EDGE_W-1:0] DWELL_TGT = EDGE_W'(DWELL_EDGES);
  localparam logic [3:0]        LOAD_LAST = 4'(LOAD_CYCLES - 1);

  state_t             state_r;
  logic               sync1_r;
  logic               sync2_r;
  logic               hist_r;
  logic               edge_s;
  logic [EDGE_W-1:0]  edge_cnt_r;
  logic [EDGE_W-1:0]  edge_cnt_inc_s;
  logic [3:0]         load_cnt_r;
  logic [1:0]         contral_r;
  logic               load_enable_r;
  logic [3:0]         load_counter_r;
  logic               busy_r;
  logic               mode_done_r;

  assign edge_s         = sync2_r & ~hist_r;
  assign edge_cnt_inc_s = edge_cnt_r + {{(EDGE_W-1){1'b0}}, 1'b1};

  // Bring div_clk_in into the CLK domain and keep one sample of history for rise detection.
  always_ff @(posedge CLK) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      hist_r  <= 1'b0;
    end else begin
      sync1_r <= bus.div_clk_in;
      sync2_r <= sync1_r;
      hist_r  <= sync2_r;
    end
  end

  // Sequencer state machine; every output is a register updated here.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_r        <= IDLE;
      edge_cnt_r     <= '0;
      load_cnt_r     <= 4'd0;
      contral_r      <= 2'b00;
      load_enable_r  <= 1'b0;
      load_counter_r <= 4'd0;
      busy_r         <= 1'b0;
      mode_done_r    <= 1'b0;
    end else begin
      mode_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          busy_r        <= 1'b0;
          load_enable_r <= 1'b0;
          edge_cnt_r    <= '0;
          if (bus.start) begin
            state_r        <= LOAD;
            load_counter_r <= bus.load_value;
            contral_r      <= 2'b00;
            load_cnt_r     <= 4'd0;
            load_enable_r  <= 1'b1;
            busy_r         <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (bus.stop) begin
            state_r       <= IDLE;
            busy_r        <= 1'b0;
            load_enable_r <= 1'b0;
            edge_cnt_r    <= '0;
          end else if (load_cnt_r == LOAD_LAST) begin
            state_r       <= RUN;
            load_enable_r <= 1'b0;
            edge_cnt_r    <= '0;
          end else begin
            load_cnt_r <= load_cnt_r + 4'd1;
          end
        end
        RUN: begin
          // stop outranks both a counted edge and a completing dwell
          if (bus.stop) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            edge_cnt_r <= '0;
          end else if (edge_s) begin
            edge_cnt_r <= edge_cnt_inc_s;
            if (edge_cnt_inc_s == DWELL_TGT) begin
              state_r     <= ADVANCE;
              mode_done_r <= 1'b1;
            end else begin
              state_r <= RUN;
            end
          end else begin
            state_r <= RUN;
          end
        end
        ADVANCE: begin
          edge_cnt_r <= '0;
          if (bus.stop) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (contral_r != 2'b11) begin
            contral_r <= contral_r + 2'b01;
            state_r   <= RUN;
          end else if (bus.loop_en) begin
            contral_r      <= 2'b00;
            load_counter_r <= bus.load_value;
            load_cnt_r     <= 4'd0;
            load_enable_r  <= 1'b1;
            state_r        <= LOAD;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r       <= IDLE;
          busy_r        <= 1'b0;
          load_enable_r <= 1'b0;
          edge_cnt_r    <= '0;
        end
      endcase
    end
  end

  assign bus.contral      = contral_r;
  assign bus.load_enable  = load_enable_r;
  assign bus.load_counter = load_counter_r;
  assign bus.busy         = busy_r;
  assign bus.mode_done    = mode_done_r;

endmodule

// File: tb/tb_divider_sequencer.sv
// Scoreboard bench for divider_sequencer: stimulus pushes the expected event stream
// (load bursts, mode completions, return to idle); a negedge monitor pops and compares.
module tb_divider_sequencer;
  localparam int DWELL   = 10;
  localparam int LOADC   = 5;
  localparam int EV_LOAD = 0;
  localparam int EV_DONE = 1;
  localparam int EV_IDLE = 2;

  typedef struct {
    int kind;
    int val;
    int aux;
  } ev_t;

  logic CLK = 1'b0;
  logic rst = 1'b1;
  always #10 CLK = ~CLK;

  divider_sequencer_if bus ();

  divider_sequencer #(
    .DWELL_EDGES(DWELL),
    .EDGE_W     (8),
    .LOAD_CYCLES(LOADC)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .bus(bus)
  );

  int  tests = 0;
  int  fails = 0;
  ev_t exp_q[$];
  int  mode_rises = 0;
  int  done_cnt = 0, load_cnt = 0, idle_cnt = 0;
  int  done_tgt = 0, load_tgt = 0, idle_tgt = 0;
  bit  mute = 1'b1;

  task automatic check(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic exp_push(input int kind, input int val, input int aux);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.aux  = aux;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input int kind, input int val, input int aux, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_%s: got value %0d aux %0d, required no event", nm, val, aux);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_kind"}, kind, e.kind);
      check({nm, "_value"}, val, e.val);
      check({nm, "_aux"}, aux, e.aux);
    end
  endtask

  // Monitor: turn output waveforms into events and score them
  logic prev_le = 1'b0, prev_md = 1'b0, prev_busy = 1'b0;
  int   le_len = 0, le_val = 0, md_len = 0;
  always @(negedge CLK) begin
    if (mute) begin
      prev_le   = 1'b0;
      prev_md   = 1'b0;
      prev_busy = 1'b0;
      le_len    = 0;
      md_len    = 0;
    end else begin
      if (bus.load_enable) begin
        if (!prev_le) begin
          le_val = int'(bus.load_counter);
          check("contral_in_load", int'(bus.contral), 0);
          check("busy_in_load", int'(bus.busy), 1);
        end
        le_len++;
      end else if (prev_le) begin
        pop_check(EV_LOAD, le_val, le_len, "load");
        le_len = 0;
        load_cnt++;
      end
      if (bus.mode_done) begin
        if (!prev_md) begin
          pop_check(EV_DONE, int'(bus.contral), mode_rises, "done");
          done_cnt++;
        end
        md_len++;
      end else if (prev_md) begin
        check("mode_done_width", md_len, 1);
        md_len = 0;
      end
      if (!bus.busy && prev_busy) begin
        pop_check(EV_IDLE, int'(bus.contral), 0, "idle");
        idle_cnt++;
      end
      prev_le   = bus.load_enable;
      prev_md   = bus.mode_done;
      prev_busy = bus.busy;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic rise();
    bus.div_clk_in = 1'b1;
    mode_rises++;
    tick($urandom_range(1, 3));
    bus.div_clk_in = 1'b0;
    tick($urandom_range(2, 5));
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    done_tgt++;
    while (done_cnt < done_tgt && k < 60) begin tick(1); k++; end
    check(nm, done_cnt, done_tgt);
    done_tgt = done_cnt;
  endtask

  task automatic wait_load(input string nm);
    int k = 0;
    load_tgt++;
    while (load_cnt < load_tgt && k < 60) begin tick(1); k++; end
    check(nm, load_cnt, load_tgt);
    load_tgt = load_cnt;
  endtask

  task automatic wait_idle(input string nm);
    int k = 0;
    idle_tgt++;
    while (idle_cnt < idle_tgt && k < 60) begin tick(1); k++; end
    check(nm, idle_cnt, idle_tgt);
    idle_tgt = idle_cnt;
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_contral"}, int'(bus.contral), 0);
    check({nm, "_load_enable"}, int'(bus.load_enable), 0);
    check({nm, "_load_counter"}, int'(bus.load_counter), 0);
    check({nm, "_busy"}, int'(bus.busy), 0);
    check({nm, "_mode_done"}, int'(bus.mode_done), 0);
  endtask

  task automatic pulse_start(input bit immune);
    bus.start = 1'b1;
    if (immune) begin
      // two divided-clock rises that are detected while the load burst is still running
      bus.div_clk_in = 1'b1;
      tick(1);
      bus.start      = 1'b0;
      bus.div_clk_in = 1'b0;
      tick(1);
      bus.div_clk_in = 1'b1;
      tick(1);
      bus.div_clk_in = 1'b0;
    end else begin
      tick(1);
      bus.start = 1'b0;
    end
  endtask

  // One sequence: passes>1 loops; cut_mode>=0 aborts (stop or reset) after 4 rises in that mode
  task automatic run_seq(input int lv0, input int passes, input int cut_mode, input bit cut_is_reset,
                         input bit immune, input bit mid_start, input int lv_next);
    int nxt;
    nxt = (lv_next < 0) ? int'($urandom_range(0, 9)) : lv_next;
    exp_push(EV_LOAD, lv0, LOADC);
    bus.load_value = 4'(lv0);
    bus.loop_en    = (passes > 1);
    pulse_start(immune);
    wait_load("load_wait");
    for (int p = 0; p < passes; p++) begin
      for (int m = 0; m < 4; m++) begin
        mode_rises = 0;
        if (m == cut_mode) begin
          repeat (4) rise();
          tick(3);
          if (cut_is_reset) begin
            mute = 1'b1;
            rst  = 1'b1;
            tick(1);
            check_all_zero("mid_reset");
            rst = 1'b0;
            exp_q.delete();
            tick(2);
            mute = 1'b0;
          end else begin
            exp_push(EV_IDLE, m, 0);
            bus.stop = 1'b1;
            tick(1);
            bus.stop = 1'b0;
            wait_idle("stop_wait");
            check("busy_after_stop", int'(bus.busy), 0);
            check("contral_after_stop", int'(bus.contral), m);
          end
          return;
        end
        exp_push(EV_DONE, m, DWELL);
        if (m == 3) begin
          if (p == passes - 1) begin
            bus.loop_en = 1'b0;
            exp_push(EV_IDLE, 3, 0);
          end else begin
            exp_push(EV_LOAD, nxt, LOADC);
          end
        end
        for (int i = 0; i < DWELL; i++) begin
          rise();
          if (m == 2 && i == DWELL / 2) bus.load_value = 4'(nxt);
          if (mid_start && m == 2 && i == 3) begin
            bus.start = 1'b1;
            tick(1);
            bus.start = 1'b0;
          end
        end
        wait_done("done_wait");
      end
      if (p == passes - 1) wait_idle("idle_wait");
      else wait_load("reload_wait");
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.loop_en    = 1'b0;
    bus.load_value = 4'd0;
    bus.div_clk_in = 1'b0;
    rst  = 1'b1;
    tick(2);
    rst  = 1'b0;
    mute = 1'b0;
    tick(50);
    check_all_zero("idle_after_reset");

    run_seq(1, 1, -1, 1'b0, 1'b0, 1'b0, -1);
    run_seq(1, 2, -1, 1'b0, 1'b0, 1'b0, 7);
    run_seq(int'($urandom_range(0, 9)), 1, 1, 1'b0, 1'b0, 1'b0, -1);
    run_seq(int'($urandom_range(0, 9)), 1, -1, 1'b0, 1'b1, 1'b1, -1);
    run_seq(int'($urandom_range(0, 9)), 1, 2, 1'b1, 1'b0, 1'b0, -1);
    run_seq(int'($urandom_range(0, 9)), 1, -1, 1'b0, 1'b0, 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      run_seq(int'($urandom_range(0, 9)), int'($urandom_range(1, 2)), -1, 1'b0,
              1'($urandom_range(0, 1)), 1'b0, -1);
    end
    tick(10);
    check("queue_drained", exp_q.size(), 0);
    check_all_zero_busy: begin
      check("final_busy", int'(bus.busy), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
